// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and constants for the memory responder slice.
//   - mem_resp_state_t : responder FSM states (IDLE, WAIT, RESP)
//   - MEM_ERR_RDATA    : read data returned for an out-of-range read
//   - BYTE_W/NUM_LANES : byte-lane geometry of the 32-bit data path
// -----------------------------------------------------------------------------
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_resp_state_t;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned DATA_W    = BYTE_W * NUM_LANES;

   localparam logic [DATA_W-1:0] MEM_ERR_RDATA = 32'hDEAD_BEEF;

endpackage : mem_responder_pkg

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Core-side memory port bundle.
//   master modport (core)      : drives mem_read, mem_write, mem_address,
//                                mem_wdata, mem_byte_enable; samples
//                                mem_rdata, mem_resp (and mem_err)
//   slave modport (responder)  : the mirror image
//   Optional macro MEM_RESPONDER_ERR_EN adds the mem_err flag.
// -----------------------------------------------------------------------------
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic                 mem_read;
   logic                 mem_write;
   logic [31:0]          mem_address;
   logic [DATA_W-1:0]    mem_wdata;
   logic [NUM_LANES-1:0] mem_byte_enable;
   logic [DATA_W-1:0]    mem_rdata;
   logic                 mem_resp;
`ifdef MEM_RESPONDER_ERR_EN
   logic                 mem_err;
`endif

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_rdata, mem_resp
`ifdef MEM_RESPONDER_ERR_EN
      , input mem_err
`endif
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_rdata, mem_resp
`ifdef MEM_RESPONDER_ERR_EN
      , output mem_err
`endif
   );

endinterface : mem_responder_if

// File: rtl/mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_responder_array
//   Single-port word array with per-byte write enables. Writes happen on the
//   rising edge; the read port is combinational from the (externally
//   registered) word index.
//   Ports:
//     clk      : clock
//     we_i     : write strobe for this cycle
//     be_i     : byte-lane enables, bit i covers [8i+7:8i]
//     idx_i    : word index
//     wdata_i  : lane-aligned write data
//     rdata_o  : word currently addressed by idx_i
// -----------------------------------------------------------------------------
module mem_responder_array
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [NUM_LANES-1:0] be_i,
   input  logic [IDX_W-1:0]     idx_i,
   input  logic [DATA_W-1:0]    wdata_i,
   output logic [DATA_W-1:0]    rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   // NOTE: the storage has no reset on purpose -- resetting every word would
   // prevent RAM inference and the contents are defined by writes only.
   // NOTE: non-blocking assignment keeps the update ordered after every
   // reader sampling this edge.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (be_i[i]) begin
               mem_q[idx_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule : mem_responder_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multicycle core's memory port. Accepts one
//   read or write request, waits LATENCY cycles from the first request cycle,
//   then completes it with a single-cycle mem_resp pulse.
//   Parameters:
//     DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//     LATENCY     : request-to-response cycles, 1..255
//     BASE_ADDR   : byte address of word 0 (word aligned)
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : mem_responder_if.slave (request inputs, rdata/resp outputs)
//   Optional macro MEM_RESPONDER_ERR_EN: out-of-range accepted addresses raise
//   mem_err with mem_resp, reads return MEM_ERR_RDATA, writes are dropped.
//   Without it addresses simply wrap modulo DEPTH_WORDS.
// -----------------------------------------------------------------------------
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 3,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // WAIT is entered with LATENCY-2 so that the RESP cycle lands on cycle LATENCY.
   localparam logic [7:0]  CNT_LOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

   mem_resp_state_t      state_q;
   logic [7:0]           cnt_q;
   logic                 op_write_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [NUM_LANES-1:0] be_q;
   logic                 resp_q;
   logic [DATA_W-1:0]    rdata_q;

   logic                 req_d;
   logic [32:0]          offset_d;
   logic [IDX_W-1:0]     idx_d;
   logic [DATA_W-1:0]    arr_rdata;
   logic [DATA_W-1:0]    resp_rdata_d;
   logic                 arr_we;
   logic                 unused_addr_bits;

   // Offset from BASE_ADDR with a borrow bit: bit 32 set means the address
   // is below the base; any bit above the index field means past the top.
   assign offset_d = {1'b0, bus.mem_address} - {1'b0, BASE_ADDR};
   assign idx_d    = offset_d[IDX_W+1:2];
   assign req_d    = bus.mem_read | bus.mem_write;

   assign unused_addr_bits = ^{offset_d[32:IDX_W+2], offset_d[1:0]};

`ifdef MEM_RESPONDER_ERR_EN
   logic err_q;
   logic err_d;

   assign err_d        = offset_d[32] | (|offset_d[31:IDX_W+2]);
   assign resp_rdata_d = err_q ? MEM_ERR_RDATA : arr_rdata;
   assign arr_we       = (state_q == RESP) & op_write_q & ~err_q;
   assign bus.mem_err  = resp_q & err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && req_d) begin
         err_q <= err_d;
      end
   end
`else
   assign resp_rdata_d = arr_rdata;
   assign arr_we       = (state_q == RESP) & op_write_q;
`endif

   // Control FSM; all request fields are captured once at acceptance so later
   // input changes cannot disturb an in-flight request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_write_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         resp_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_d) begin
                  op_write_q <= bus.mem_write;   // write wins over read
                  idx_q      <= idx_d;
                  wdata_q    <= bus.mem_wdata;
                  be_q       <= bus.mem_byte_enable;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                     resp_q  <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 8'd0) begin
                  state_q <= RESP;
                  resp_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               if (!op_write_q) begin
                  rdata_q <= resp_rdata_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // During a read RESP the array word is presented directly; rdata_q keeps
   // it afterwards so mem_rdata holds until the next read response.
   assign bus.mem_rdata = (state_q == RESP && !op_write_q) ? resp_rdata_d : rdata_q;
   assign bus.mem_resp  = resp_q;

   mem_responder_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .be_i    (be_q),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Two responders share clk/rst: index 0 is LATENCY=3, DEPTH_WORDS=1024;
//   index 1 is LATENCY=1, DEPTH_WORDS=16. A transaction-level model predicts
//   the response cycle, read data, held data and error flag; directed
//   sequences pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam logic [31:0] BASE_A = 32'h0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // bench-side request drivers and observed outputs, indexed by DUT
   logic        rd_s    [2];
   logic        wr_s    [2];
   logic [31:0] addr_s  [2];
   logic [31:0] wdata_s [2];
   logic [3:0]  be_s    [2];
   logic [31:0] rdata_s [2];
   logic        resp_s  [2];
   logic        err_s   [2];

   mem_responder_if if3 ();
   mem_responder_if if1 ();

   assign if3.mem_read        = rd_s[0];
   assign if3.mem_write       = wr_s[0];
   assign if3.mem_address     = addr_s[0];
   assign if3.mem_wdata       = wdata_s[0];
   assign if3.mem_byte_enable = be_s[0];
   assign rdata_s[0]          = if3.mem_rdata;
   assign resp_s[0]           = if3.mem_resp;
   assign if1.mem_read        = rd_s[1];
   assign if1.mem_write       = wr_s[1];
   assign if1.mem_address     = addr_s[1];
   assign if1.mem_wdata       = wdata_s[1];
   assign if1.mem_byte_enable = be_s[1];
   assign rdata_s[1]          = if1.mem_rdata;
   assign resp_s[1]           = if1.mem_resp;
`ifdef MEM_RESPONDER_ERR_EN
   assign err_s[0] = if3.mem_err;
   assign err_s[1] = if1.mem_err;
`else
   assign err_s[0] = 1'b0;
   assign err_s[1] = 1'b0;
`endif

   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(BASE_A)) u_dut_l3 (
      .clk (clk), .rst (rst), .bus (if3));
   mem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(BASE_A)) u_dut_l1 (
      .clk (clk), .rst (rst), .bus (if1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic int lat_of(int k);
      return (k == 0) ? 3 : 1;
   endfunction

   function automatic logic [31:0] dep_of(int k);
      return (k == 0) ? 32'd1024 : 32'd16;
   endfunction

   function automatic int widx(int k, logic [31:0] a);
      return int'(((a - BASE_A) >> 2) % dep_of(k));
   endfunction

   function automatic bit model_err(int k, logic [31:0] a);
`ifdef MEM_RESPONDER_ERR_EN
      return (longint'(a) < longint'(BASE_A)) ||
             (longint'(a) >= longint'(BASE_A) + 4 * longint'(dep_of(k)));
`else
      return (k < 0) && (a == 32'h0);   // never true: addresses wrap
`endif
   endfunction

   bit          pend       [2];
   int          acc_cyc    [2];
   bit          p_wr       [2];
   logic [31:0] p_addr     [2];
   logic [31:0] p_data     [2];
   logic [3:0]  p_be       [2];
   logic [31:0] last_rd    [2];
   bit          last_known [2];
   int          free_from  [2];
   logic [31:0] mdl_mem    [2][1024];
   bit          mdl_known  [2][1024];

   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 1024; i++) mdl_known[k][i] = 1'b0;
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            pend[k] = 1'b0; last_rd[k] = 32'h0; last_known[k] = 1'b1; free_from[k] = 0;
            check($sformatf("rst_resp%0d", k), 32'(resp_s[k]), 32'h0);
            check($sformatf("rst_rdata%0d", k), rdata_s[k], 32'h0);
         end else begin
            bit exp_resp;
            int ix;
            bit e;
            exp_resp = pend[k] && (cyc == acc_cyc[k] + lat_of(k));
            check($sformatf("resp%0d@%0d", k, cyc), 32'(resp_s[k]), 32'(exp_resp));
            if (exp_resp) begin
               ix = widx(k, p_addr[k]);
               e  = model_err(k, p_addr[k]);
`ifdef MEM_RESPONDER_ERR_EN
               check($sformatf("err%0d@%0d", k, cyc), 32'(err_s[k]), 32'(e));
`endif
               if (!p_wr[k]) begin
                  if (e) begin
                     check($sformatf("rdata_err%0d", k), rdata_s[k], 32'hDEAD_BEEF);
                     last_rd[k] = 32'hDEAD_BEEF; last_known[k] = 1'b1;
                  end else if (mdl_known[k][ix]) begin
                     check($sformatf("rdata%0d@%0d", k, cyc), rdata_s[k], mdl_mem[k][ix]);
                     last_rd[k] = mdl_mem[k][ix]; last_known[k] = 1'b1;
                  end else begin
                     last_known[k] = 1'b0;
                  end
               end else begin
                  if (last_known[k])
                     check($sformatf("wr_rdata_hold%0d", k), rdata_s[k], last_rd[k]);
                  if (!e) begin
                     for (int b = 0; b < 4; b++)
                        if (p_be[k][b]) mdl_mem[k][ix][8*b +: 8] = p_data[k][8*b +: 8];
                     if (p_be[k] == 4'hF) mdl_known[k][ix] = 1'b1;
                  end
               end
               pend[k] = 1'b0;
               free_from[k] = cyc + 1;
            end else begin
               if (last_known[k])
                  check($sformatf("rdata_hold%0d@%0d", k, cyc), rdata_s[k], last_rd[k]);
`ifdef MEM_RESPONDER_ERR_EN
               check($sformatf("err_idle%0d@%0d", k, cyc), 32'(err_s[k]), 32'h0);
`endif
            end
            if (!pend[k] && cyc >= free_from[k] && (rd_s[k] || wr_s[k])) begin
               pend[k] = 1'b1; acc_cyc[k] = cyc; p_wr[k] = wr_s[k];
               p_addr[k] = addr_s[k]; p_data[k] = wdata_s[k]; p_be[k] = be_s[k];
            end
         end
      end
   end

   // --------------------------------------------------------------- driver
   // Called at the start of a cycle (posedge+1); returns at the start of the
   // cycle following the response, with the request already dropped.
   task automatic do_req(input int k, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         output logic [31:0] rdata, output int lat, output logic err);
      int c0;
      bit got;
      rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; wdata_s[k] = d; be_s[k] = be;
      c0 = cyc; got = 1'b0; rdata = '0; lat = -1; err = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (resp_s[k]) begin
            got = 1'b1; rdata = rdata_s[k]; err = err_s[k]; lat = cyc - c0;
         end
      end
      check($sformatf("no_timeout%0d_%h", k, a), 32'(got), 32'h1);
      @(posedge clk); #1;
      rd_s[k] = 1'b0; wr_s[k] = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          c_s;
      int          nresp;

      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rd_s[k] = 0; wr_s[k] = 0; addr_s[k] = 0; wdata_s[k] = 0; be_s[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_resp_l3", 32'(resp_s[0]), 32'h0);
      check("reset_rdata_l3", rdata_s[0], 32'h0);
      check("reset_resp_l1", 32'(resp_s[1]), 32'h0);
      rst = 1'b1;

      // latency 3 read of preloaded zero
      do_req(0, 0, 1, 32'h0, 32'h0, 4'hF, rd, lat, er);
      do_req(0, 1, 0, 32'h0, 32'h0, 4'h0, rd, lat, er);
      check("lat3_cycles", 32'(lat), 32'd3);
      check("lat3_rdata0", rd, 32'h0);

      // byte-enable merge
      do_req(0, 0, 1, 32'h10, 32'h1122_3344, 4'b1111, rd, lat, er);
      do_req(0, 0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, lat, er);
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, rd, lat, er);
      check("be_merge", rd, 32'h11BB_33DD);

      // zero byte enable still responds, changes nothing
      do_req(0, 0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, lat, er);
      check("be0_lat", 32'(lat), 32'd3);
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, rd, lat, er);
      check("be0_nochange", rd, 32'h11BB_33DD);

      // last word in range
      do_req(0, 0, 1, 32'hFFC, 32'h600D_CAFE, 4'hF, rd, lat, er);
      do_req(0, 1, 0, 32'hFFC, 32'h0, 4'h0, rd, lat, er);
      check("top_word", rd, 32'h600D_CAFE);

      // one past the top: wraps to word 4 or errors
      do_req(0, 1, 0, 32'h1010, 32'h0, 4'h0, rd, lat, er);
`ifdef MEM_RESPONDER_ERR_EN
      check("oob_l3_err", 32'(er), 32'h1);
      check("oob_l3_rdata", rd, 32'hDEAD_BEEF);
`else
      check("wrap_l3_rdata", rd, 32'h11BB_33DD);
`endif

      // read and write both high: write wins, rdata keeps last read
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, rd, lat, er);
      do_req(0, 1, 1, 32'h30, 32'h5555_AAAA, 4'hF, rd, lat, er);
      check("both_rdata_unchanged", rd, 32'h11BB_33DD);
      do_req(0, 1, 0, 32'h30, 32'h0, 4'h0, rd, lat, er);
      check("both_was_write", rd, 32'h5555_AAAA);

      // reset during WAIT of a write aborts it
      do_req(0, 0, 1, 32'h20, 32'hCAFE_0001, 4'hF, rd, lat, er);
      wr_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h0BAD_0BAD; be_s[0] = 4'hF;
      @(posedge clk); #1;
      rst = 1'b0;
      wr_s[0] = 1'b0;
      nresp = 0;
      repeat (3) begin
         @(negedge clk);
         if (resp_s[0]) nresp++;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      check("abort_no_resp", 32'(nresp), 32'd0);
      do_req(0, 1, 0, 32'h20, 32'h0, 4'h0, rd, lat, er);
      check("abort_old_value", rd, 32'hCAFE_0001);

      // latency 1: write then back-to-back read sees the new data
      do_req(1, 0, 1, 32'h0, 32'h1234_5678, 4'hF, rd, lat, er);
      check("lat1_cycles", 32'(lat), 32'd1);
      c_s = cyc;
      do_req(1, 0, 1, 32'h8, 32'h0000_00A5, 4'hF, rd, lat, er);
      do_req(1, 1, 0, 32'h8, 32'h0, 4'h0, rd, lat, er);
      check("l1_raw_data", rd, 32'h0000_00A5);
      check("l1_pair_cycles", 32'(cyc - c_s), 32'd4);

      // address 0x40 on the 16-word array
      do_req(1, 1, 0, 32'h40, 32'h0, 4'h0, rd, lat, er);
`ifdef MEM_RESPONDER_ERR_EN
      check("oob_l1_err", 32'(er), 32'h1);
      check("oob_l1_rdata", rd, 32'hDEAD_BEEF);
`else
      check("wrap_l1_rdata", rd, 32'h1234_5678);
`endif
      do_req(1, 0, 1, 32'h40, 32'hFEED_FACE, 4'hF, rd, lat, er);
      do_req(1, 1, 0, 32'h0, 32'h0, 4'h0, rd, lat, er);
`ifdef MEM_RESPONDER_ERR_EN
      check("oob_write_dropped", rd, 32'h1234_5678);
`else
      check("wrap_write_word0", rd, 32'hFEED_FACE);
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_responder
